// File: rtl/frame_manager_pkg.sv
// Shared draw-bus geometry, colour depth and source IDs.
// Imported by every unit that drives or consumes the draw bus.
package frame_manager_pkg;

    localparam int DRAW_WIDTH        = 160;
    localparam int DRAW_HEIGHT       = 120;
    localparam int DRAW_WIDTH_ADDRW  = 8;
    localparam int DRAW_HEIGHT_ADDRW = 7;
    localparam int COLOR_DEPTH       = 9;
    localparam int SOURCE_SEL_ADDRW  = 2;
    localparam int FB_ADDRW          = $clog2(DRAW_WIDTH * DRAW_HEIGHT);

    localparam logic [SOURCE_SEL_ADDRW-1:0] SOURCE_ID_STARFIELD = 2'd0;
    localparam logic [SOURCE_SEL_ADDRW-1:0] SOURCE_ID_SPRITES   = 2'd1;
    localparam logic [SOURCE_SEL_ADDRW-1:0] SOURCE_ID_ENEMIES   = 2'd2;
    localparam logic [SOURCE_SEL_ADDRW-1:0] SOURCE_ID_HUD       = 2'd3;

    function automatic logic [FB_ADDRW-1:0] fb_lin(
        input logic [DRAW_WIDTH_ADDRW-1:0]  x,
        input logic [DRAW_HEIGHT_ADDRW-1:0] y
    );
        return FB_ADDRW'(y) * FB_ADDRW'(DRAW_WIDTH) + FB_ADDRW'(x);
    endfunction

endpackage

// File: rtl/draw_manager_fb_addr_gen.sv
// Registers one framebuffer write: on-screen check, y*W+x, colour.
// Off-screen requests produce no write and leave addr/data untouched.
module fb_addr_gen
    import frame_manager_pkg::*;
(
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         i_en,
    input  logic [DRAW_WIDTH_ADDRW-1:0]  i_x,
    input  logic [DRAW_HEIGHT_ADDRW-1:0] i_y,
    input  logic [COLOR_DEPTH-1:0]       i_color,
    output logic                         o_we,
    output logic [FB_ADDRW-1:0]          o_addr,
    output logic [COLOR_DEPTH-1:0]       o_wdata
);

    logic                   r_we;
    logic [FB_ADDRW-1:0]    r_addr;
    logic [COLOR_DEPTH-1:0] r_wdata;
    logic                   w_hit;

    assign w_hit = i_en
                && (i_x < DRAW_WIDTH_ADDRW'(DRAW_WIDTH))
                && (i_y < DRAW_HEIGHT_ADDRW'(DRAW_HEIGHT));

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_hit;
            if (w_hit) begin
                r_addr  <= fb_lin(i_x, i_y);
                r_wdata <= i_color;
            end
        end
    end

    assign o_we    = r_we;
    assign o_addr  = r_addr;
    assign o_wdata = r_wdata;

endmodule

// File: rtl/draw_manager.sv
// Per-frame back-buffer clear, round-robin source grant, swap request.
// All framebuffer writes go through one registered fb_addr_gen.
module draw_manager
    import frame_manager_pkg::*;
#(
    parameter int NUM_SOURCES   = 4,
    parameter int CLEAR_EN      = 1,
    parameter int GRANT_TIMEOUT = 1023
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         frame_start,
    input  logic                         swap_ack,
    input  logic [COLOR_DEPTH-1:0]       bg_color,
    output logic [SOURCE_SEL_ADDRW-1:0]  write_source_sel,
    output logic                         write_awaited,
    input  logic                         write_active,
    input  logic [COLOR_DEPTH-1:0]       write_color_data,
    input  logic                         write_transparent,
    input  logic [DRAW_WIDTH_ADDRW-1:0]  write_x_addr,
    input  logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr,
    output logic                         fb_we,
    output logic [FB_ADDRW-1:0]          fb_addr,
    output logic [COLOR_DEPTH-1:0]       fb_wdata,
    output logic                         frame_done,
    output logic                         busy
);

    localparam int TMO_W = $clog2(GRANT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, CLEAR, GRANT, WAIT, STREAM, NEXT, DONE
    } state_t;

    state_t                         r_state;
    logic [SOURCE_SEL_ADDRW-1:0]    r_idx;
    logic                           r_awaited;
    logic                           r_done;
    logic                           r_busy;
    logic [TMO_W-1:0]               r_tmo;
    logic [DRAW_WIDTH_ADDRW-1:0]    r_cx;
    logic [DRAW_HEIGHT_ADDRW-1:0]   r_cy;

    logic                           w_x_end;
    logic                           w_clr_last;
    logic [DRAW_WIDTH_ADDRW-1:0]    w_nx;
    logic [DRAW_HEIGHT_ADDRW-1:0]   w_ny;
    logic                           w_en;
    logic [DRAW_WIDTH_ADDRW-1:0]    w_x;
    logic [DRAW_HEIGHT_ADDRW-1:0]   w_y;
    logic [COLOR_DEPTH-1:0]         w_color;

    assign w_x_end    = (r_cx == DRAW_WIDTH_ADDRW'(DRAW_WIDTH - 1));
    assign w_clr_last = w_x_end
                     && (r_cy == DRAW_HEIGHT_ADDRW'(DRAW_HEIGHT - 1));
    assign w_nx       = w_x_end ? '0 : r_cx + 1'b1;
    assign w_ny       = w_x_end ? r_cy + 1'b1 : r_cy;

    // Clear feeds the next coordinate so fb_addr lines up with the counter.
    always_comb begin
        w_en    = 1'b0;
        w_x     = '0;
        w_y     = '0;
        w_color = bg_color;
        unique case (r_state)
            IDLE:    w_en = frame_start && (CLEAR_EN != 0);
            CLEAR: begin
                w_en = !w_clr_last;
                w_x  = w_nx;
                w_y  = w_ny;
            end
            STREAM: begin
                w_en    = write_active && !write_transparent;
                w_x     = write_x_addr;
                w_y     = write_y_addr;
                w_color = write_color_data;
            end
            default: w_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_awaited <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_tmo     <= '0;
            r_cx      <= '0;
            r_cy      <= '0;
        end else begin
            unique case (r_state)
                IDLE: if (frame_start) begin
                    r_busy <= 1'b1;
                    r_cx   <= '0;
                    r_cy   <= '0;
                    r_idx  <= '0;
                    if (CLEAR_EN != 0) begin
                        r_state <= CLEAR;
                    end else begin
                        r_state   <= GRANT;
                        r_awaited <= 1'b1;
                    end
                end
                CLEAR: if (w_clr_last) begin
                    r_state   <= GRANT;
                    r_idx     <= '0;
                    r_awaited <= 1'b1;
                end else begin
                    r_cx <= w_nx;
                    r_cy <= w_ny;
                end
                GRANT: begin
                    r_state <= WAIT;
                    r_tmo   <= '0;
                end
                WAIT: begin
                    r_tmo <= r_tmo + 1'b1;
                    if (write_active) begin
                        r_state   <= STREAM;
                        r_awaited <= 1'b0;
                    end else if (r_tmo == TMO_W'(GRANT_TIMEOUT - 1)) begin
                        r_state   <= NEXT;
                        r_awaited <= 1'b0;
                    end
                end
                STREAM: if (!write_active) r_state <= NEXT;
                NEXT: if (r_idx == SOURCE_SEL_ADDRW'(NUM_SOURCES - 1)) begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                end else begin
                    r_idx     <= r_idx + 1'b1;
                    r_state   <= GRANT;
                    r_awaited <= 1'b1;
                end
                DONE: if (swap_ack) begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_idx   <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    fb_addr_gen u_fb_addr_gen (
        .clk     (clk),
        .resetN  (resetN),
        .i_en    (w_en),
        .i_x     (w_x),
        .i_y     (w_y),
        .i_color (w_color),
        .o_we    (fb_we),
        .o_addr  (fb_addr),
        .o_wdata (fb_wdata)
    );

    assign write_source_sel = r_idx;
    assign write_awaited    = r_awaited;
    assign frame_done       = r_done;
    assign busy             = r_busy;

endmodule

// File: tb/tb_draw_manager.sv
// Directed bench for draw_manager: clear, stream, clipping,
// grant timeout, swap handshake and mid-stream reset.
module tb_draw_manager;
    import frame_manager_pkg::*;

    logic                         clk = 1'b0;
    logic                         resetN = 1'b0;
    logic                         frame_start = 1'b0;
    logic                         swap_ack = 1'b0;
    logic [COLOR_DEPTH-1:0]       bg_color = '0;
    logic [SOURCE_SEL_ADDRW-1:0]  write_source_sel;
    logic                         write_awaited;
    logic                         write_active = 1'b0;
    logic [COLOR_DEPTH-1:0]       write_color_data = '0;
    logic                         write_transparent = 1'b0;
    logic [DRAW_WIDTH_ADDRW-1:0]  write_x_addr = '0;
    logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr = '0;
    logic                         fb_we;
    logic [FB_ADDRW-1:0]          fb_addr;
    logic [COLOR_DEPTH-1:0]       fb_wdata;
    logic                         frame_done;
    logic                         busy;

    int errs = 0;
    int checks = 0;

    draw_manager dut (
        .clk               (clk),
        .resetN            (resetN),
        .frame_start       (frame_start),
        .swap_ack          (swap_ack),
        .bg_color          (bg_color),
        .write_source_sel  (write_source_sel),
        .write_awaited     (write_awaited),
        .write_active      (write_active),
        .write_color_data  (write_color_data),
        .write_transparent (write_transparent),
        .write_x_addr      (write_x_addr),
        .write_y_addr      (write_y_addr),
        .fb_we             (fb_we),
        .fb_addr           (fb_addr),
        .fb_wdata          (fb_wdata),
        .frame_done        (frame_done),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input string tag,
                        input logic [DRAW_WIDTH_ADDRW-1:0] x,
                        input logic [DRAW_HEIGHT_ADDRW-1:0] y,
                        input logic [COLOR_DEPTH-1:0] c,
                        input logic t, input logic exp_we,
                        input logic [FB_ADDRW-1:0] exp_addr);
        write_active      = 1'b1;
        write_x_addr      = x;
        write_y_addr      = y;
        write_color_data  = c;
        write_transparent = t;
        tick();
        chk({tag, "_we"}, 32'(fb_we), 32'(exp_we));
        if (exp_we) begin
            chk({tag, "_addr"}, 32'(fb_addr), 32'(exp_addr));
            chk({tag, "_data"}, 32'(fb_wdata), 32'(c));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int nw;
        int n;
        int g;

        // Reset state
        repeat (3) tick();
        chk("rst_we", 32'(fb_we), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_await", 32'(write_awaited), 0);
        chk("rst_sel", 32'(write_source_sel), 0);
        chk("rst_addr", 32'(fb_addr), 0);
        resetN = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 0);

        // Clear: 19200 consecutive writes 0..19199
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("clr_busy", 32'(busy), 1);
        bad = 0;
        for (int i = 0; i < 19200; i++) begin
            if (!(fb_we === 1'b1 && fb_addr === FB_ADDRW'(i)
                  && fb_wdata === '0))
                bad++;
            tick();
        end
        chk("clr_bad", 32'(bad), 0);
        chk("g0_we", 32'(fb_we), 0);
        chk("g0_await", 32'(write_awaited), 1);
        chk("g0_sel", 32'(write_source_sel), 0);

        // Source 0: active already in GRANT, 50 beats at (5,2)
        write_active     = 1'b1;
        write_x_addr     = 8'd5;
        write_y_addr     = 7'd2;
        write_color_data = 9'h1FF;
        tick();
        chk("w0_await", 32'(write_awaited), 1);
        tick();
        chk("s0_await", 32'(write_awaited), 0);
        chk("s0_lat_we", 32'(fb_we), 0);
        bad = 0;
        nw = 0;
        for (int j = 0; j < 50; j++) begin
            tick();
            if (fb_we === 1'b1) nw++;
            if (!(fb_we === 1'b1 && fb_addr === 15'd325
                  && fb_wdata === 9'h1FF))
                bad++;
        end
        chk("s0_bad", 32'(bad), 0);
        chk("s0_nw", 32'(nw), 50);
        write_active = 1'b0;
        tick();
        chk("s0_end_we", 32'(fb_we), 0);
        tick();
        chk("g1_sel", 32'(write_source_sel), 1);
        chk("g1_await", 32'(write_awaited), 1);
        chk("g1_we", 32'(fb_we), 0);

        // Source 1: clipping and transparency
        write_active = 1'b1;
        tick();
        tick();
        beat("b_ok", 8'd10, 7'd3, 9'h0AA, 1'b0, 1'b1, 15'd490);
        beat("b_x200", 8'd200, 7'd3, 9'h0AA, 1'b0, 1'b0, 15'd0);
        beat("b_y125", 8'd10, 7'd125, 9'h0AA, 1'b0, 1'b0, 15'd0);
        beat("b_last", 8'd159, 7'd119, 9'h123, 1'b0, 1'b1, 15'd19199);
        beat("b_transp", 8'd7, 7'd0, 9'h077, 1'b1, 1'b0, 15'd0);
        beat("b_org", 8'd0, 7'd0, 9'h055, 1'b0, 1'b1, 15'd0);
        write_active      = 1'b0;
        write_transparent = 1'b0;
        tick();
        chk("s1_end_we", 32'(fb_we), 0);
        tick();
        chk("g2_sel", 32'(write_source_sel), 2);

        // Source 2 silent: 1 GRANT + 1023 WAIT cycles, no writes
        n = 0;
        nw = 0;
        g = 0;
        while (write_source_sel === 2'd2 && g < 2000) begin
            if (write_awaited === 1'b1) n++;
            if (fb_we === 1'b1) nw++;
            tick();
            g++;
        end
        chk("tmo_bound", 32'(g < 2000), 1);
        chk("tmo_cycles", 32'(n), 1024);
        chk("tmo_writes", 32'(nw), 0);
        chk("g3_sel", 32'(write_source_sel), 3);
        chk("g3_await", 32'(write_awaited), 1);

        // Source 3: one beat, then swap handshake
        write_active = 1'b1;
        tick();
        tick();
        beat("b3", 8'd1, 7'd1, 9'h001, 1'b0, 1'b1, 15'd161);
        write_active = 1'b0;
        tick();
        chk("s3_end_we", 32'(fb_we), 0);
        chk("s3_done", 32'(frame_done), 0);
        swap_ack = 1'b1;
        tick();
        swap_ack = 1'b0;
        chk("dn_done", 32'(frame_done), 1);
        chk("dn_busy", 32'(busy), 1);
        repeat (3) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (6) tick();
        chk("dn_hold", 32'(frame_done), 1);
        chk("dn_hold_we", 32'(fb_we), 0);
        swap_ack = 1'b1;
        tick();
        swap_ack = 1'b0;
        chk("sw_done", 32'(frame_done), 0);
        chk("sw_busy", 32'(busy), 0);
        chk("sw_sel", 32'(write_source_sel), 0);
        tick();
        chk("fs_ignored", 32'(busy), 0);
        chk("fs_ign_we", 32'(fb_we), 0);

        // Second frame: reset while source 1 streams
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        g = 0;
        while (write_awaited !== 1'b1 && g < 25000) begin
            tick();
            g++;
        end
        chk("f2_bound", 32'(g < 25000), 1);
        write_active = 1'b1;
        tick();
        tick();
        write_active = 1'b0;
        tick();
        tick();
        chk("f2_sel1", 32'(write_source_sel), 1);
        write_active = 1'b1;
        tick();
        tick();
        beat("b_pre", 8'd2, 7'd0, 9'h005, 1'b0, 1'b1, 15'd2);
        resetN = 1'b0;
        tick();
        chk("ar_we", 32'(fb_we), 0);
        chk("ar_await", 32'(write_awaited), 0);
        chk("ar_sel", 32'(write_source_sel), 0);
        chk("ar_busy", 32'(busy), 0);
        resetN = 1'b1;
        write_active = 1'b0;
        tick();
        chk("ar_idle", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
